// File: rtl/core_v_mcu_axi_pkg.sv
// rtl/core_v_mcu_axi_pkg.sv - AXI4 channel types and encodings shared by the MCU fabric
package core_v_mcu_axi_pkg;

  localparam int AxiAddrWidth = 32;
  localparam int AxiDataWidth = 64;
  localparam int AxiIdWidth   = 4;
  localparam int AxiStrbWidth = AxiDataWidth / 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiStrbWidth-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;

endpackage

// File: rtl/core_v_mcu_pkg.sv
// rtl/core_v_mcu_pkg.sv - SRAM geometry and bridge FSM state encodings
package core_v_mcu_pkg;

  localparam int SramNumWords    = 16384;
  localparam int SramWordOffBits = 3;

  typedef logic [2:0] bridge_state_t;

  localparam bridge_state_t StIdle      = 3'd0;
  localparam bridge_state_t StWrite     = 3'd1;
  localparam bridge_state_t StWriteResp = 3'd2;
  localparam bridge_state_t StReadReq   = 3'd3;
  localparam bridge_state_t StReadData  = 3'd4;
  localparam bridge_state_t StReadResp  = 3'd5;

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - next beat byte address and unsupported-burst detect
module axi_burst_addr
  import core_v_mcu_axi_pkg::*;
(
  input  logic [AxiAddrWidth-1:0] addr,
  input  logic [2:0]              size,
  input  logic [1:0]              burst,
  output logic [AxiAddrWidth-1:0] next_addr,
  output logic                    burst_err
);

  // INCR rolls over the full AXI address space; range checking happens downstream
  assign next_addr = (burst == BurstFixed) ? addr : addr + (AxiAddrWidth'(1) << size);
  assign burst_err = (burst == BurstWrap) || (burst == 2'b11);

endmodule

// File: rtl/axi_sram_bridge.sv
// rtl/axi_sram_bridge.sv - AXI4 slave to single-port SRAM bridge, one transaction in flight
module axi_sram_bridge
  import core_v_mcu_pkg::*;
  import core_v_mcu_axi_pkg::*;
#(
  parameter int NumWords  = SramNumWords,
  parameter int DataWidth = AxiDataWidth
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  axi_req_t                    axi_req_i,
  output axi_resp_t                   axi_resp_o,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [$clog2(NumWords)-1:0] sram_addr_o,
  output logic [DataWidth-1:0]        sram_wdata_o,
  output logic [DataWidth/8-1:0]      sram_be_o,
  input  logic [DataWidth-1:0]        sram_rdata_i
);

  localparam int SramAddrWidth = $clog2(NumWords);
  localparam int WordAddrWidth = AxiAddrWidth - SramWordOffBits;

  bridge_state_t           state_q;
  logic [AxiIdWidth-1:0]   id_q;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic                    rr_read_q;
  logic                    ready_en_q;
  logic                    beat_ok_q;
  logic [DataWidth-1:0]    rdata_q;

  logic [AxiAddrWidth-1:0]  next_addr;
  logic                     burst_err;
  logic [WordAddrWidth-1:0] word_addr;
  logic                     in_range;
  logic                     beat_ok;
  logic                     last_beat;
  logic                     idle_rdy;
  logic                     both_valid;
  logic                     aw_ready;
  logic                     ar_ready;
  logic                     aw_hs;
  logic                     ar_hs;
  logic                     w_strobe;

  axi_burst_addr u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .burst_err (burst_err)
  );

  assign word_addr = addr_q[AxiAddrWidth-1:SramWordOffBits];
  assign in_range  = word_addr < WordAddrWidth'(NumWords);
  assign beat_ok   = in_range && !burst_err;
  assign last_beat = (beat_q == len_q);

  // Readies stay low until the first clock after reset release
  assign idle_rdy   = (state_q == StIdle) && ready_en_q;
  assign both_valid = axi_req_i.aw_valid && axi_req_i.ar_valid;
  assign aw_ready   = idle_rdy && !(both_valid && rr_read_q);
  assign ar_ready   = idle_rdy && !(both_valid && !rr_read_q);
  assign aw_hs      = aw_ready && axi_req_i.aw_valid;
  assign ar_hs      = ar_ready && axi_req_i.ar_valid;

  assign w_strobe = (state_q == StWrite) && axi_req_i.w_valid && beat_ok;

  assign sram_req_o   = w_strobe || ((state_q == StReadReq) && beat_ok);
  assign sram_we_o    = w_strobe;
  assign sram_addr_o  = addr_q[SramWordOffBits +: SramAddrWidth];
  assign sram_wdata_o = axi_req_i.w.data;
  assign sram_be_o    = w_strobe ? axi_req_i.w.strb : '0;

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.w_ready  = (state_q == StWrite);
    axi_resp_o.b_valid  = (state_q == StWriteResp);
    axi_resp_o.b.id     = id_q;
    axi_resp_o.b.resp   = err_q ? RespSlverr : RespOkay;
    axi_resp_o.r_valid  = (state_q == StReadResp);
    axi_resp_o.r.id     = id_q;
    axi_resp_o.r.data   = rdata_q;
    axi_resp_o.r.resp   = beat_ok_q ? RespOkay : RespSlverr;
    axi_resp_o.r.last   = last_beat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      rr_read_q  <= 1'b0;
      ready_en_q <= 1'b0;
      beat_ok_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        StIdle: begin
          beat_q <= '0;
          err_q  <= 1'b0;
          if (aw_hs) begin
            id_q    <= axi_req_i.aw.id;
            addr_q  <= axi_req_i.aw.addr;
            len_q   <= axi_req_i.aw.len;
            size_q  <= axi_req_i.aw.size;
            burst_q <= axi_req_i.aw.burst;
            state_q <= StWrite;
          end else if (ar_hs) begin
            id_q    <= axi_req_i.ar.id;
            addr_q  <= axi_req_i.ar.addr;
            len_q   <= axi_req_i.ar.len;
            size_q  <= axi_req_i.ar.size;
            burst_q <= axi_req_i.ar.burst;
            state_q <= StReadReq;
          end
          // Only contested cycles flip priority, so back-to-back collisions alternate
          if (both_valid && ready_en_q) begin
            rr_read_q <= !rr_read_q;
          end
        end
        StWrite: begin
          if (axi_req_i.w_valid) begin
            if (!beat_ok || (axi_req_i.w.last != last_beat)) begin
              err_q <= 1'b1;
            end
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
            if (last_beat) begin
              state_q <= StWriteResp;
            end
          end
        end
        StWriteResp: begin
          if (axi_req_i.b_ready) begin
            state_q <= StIdle;
          end
        end
        StReadReq: begin
          beat_ok_q <= beat_ok;
          state_q   <= StReadData;
        end
        StReadData: begin
          rdata_q <= beat_ok_q ? sram_rdata_i : '0;
          state_q <= StReadResp;
        end
        StReadResp: begin
          if (axi_req_i.r_ready) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              addr_q  <= next_addr;
              beat_q  <= beat_q + 8'd1;
              state_q <= StReadReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
